// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for the IF fetch port and the MEM load/store port.
// Serialises accesses, waits out the RAM read latency and stalls the pipe.
module mem_port_arbiter #(
    parameter int LATENCY      = 2,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT     = 4'(LATENCY);
    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  run_q, run_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic d_req;
    logic fetch_win;
    logic data_win;

    assign d_req     = d_rd | d_wr;
    // Fetch only beats data once a run of data grants has starved it.
    assign fetch_win = if_req & (~d_req | (run_q == RUN_MAX));
    assign data_win  = d_req & ~fetch_win;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        en_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (fetch_win | data_win) begin
                    en_d    = 1'b1;
                    owner_d = data_win;
                    if (data_win) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (!if_req) begin
                            run_d = 4'd0;
                        end else if (run_q != RUN_MAX) begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = 32'h0;
                        run_d   = 4'd0;
                    end
                    // A simultaneous load and store is a store.
                    if (data_win & d_wr) begin
                        we_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = LAT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (owner_q) begin
                        d_rdata_d = ram_rdata;
                    end else begin
                        if_rdata_d = ram_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            run_q      <= 4'd0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign ram_en    = en_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = (state_q == DONE) & ~owner_q;
    assign d_done    = (state_q == DONE) & owner_q;
    assign stall     = (if_req & ~if_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// hand-written sequences for arbitration, runs and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_done, d_done, ram_en, ram_we, stall;
    logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

    logic        if_done4, d_done4, ram_en4, ram_we4, stall4;
    logic [31:0] if_rdata4, d_rdata4, ram_addr4, ram_wdata4, ram_rdata4;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(2), .MAX_DATA_RUN(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_rdata(if_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall(stall)
    );

    mem_port_arbiter #(.LATENCY(4), .MAX_DATA_RUN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done4), .if_rdata(if_rdata4),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done4), .d_rdata(d_rdata4),
        .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4),
        .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4),
        .stall(stall4)
    );

    // RAM models: read data is valid only in the cycle ending at edge E(LATENCY).
    logic [31:0] mem [0:255];
    bit          loaded;
    bit          rd_v;
    logic [7:0]  rd_a;
    bit   [2:0]  p4;

    always @(posedge clk) begin
        if (!loaded) begin
            mem[8'h10] <= 32'h8C010004;
            mem[8'h40] <= 32'h12345678;
            mem[8'h20] <= 32'hCAFEF00D;
            loaded     <= 1'b1;
        end else if (ram_en && ram_we) begin
            mem[ram_addr[9:2]] <= ram_wdata;
        end
        rd_v <= ram_en & ~ram_we;
        rd_a <= ram_addr[9:2];
        p4   <= {p4[1:0], ram_en4 & ~ram_we4};
    end

    assign ram_rdata  = rd_v ? mem[rd_a] : 32'hBAD0BAD0;
    assign ram_rdata4 = p4[2] ? mem[ram_addr4[9:2]] : 32'hBAD0BAD0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 load+store
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        bit   got;
        bit   is_data;
        logic dn;
        is_data = (v.kind != 0);
        @(negedge clk);
        if_req  = (v.kind == 0);
        if_addr = v.addr;
        d_rd    = (v.kind == 1) || (v.kind == 3);
        d_wr    = (v.kind >= 2);
        d_addr  = v.addr;
        d_wdata = v.wdata;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk($sformatf("v%0d_ram_en", idx), 32'(ram_en), 32'd1);
                chk($sformatf("v%0d_ram_addr", idx), ram_addr, v.addr);
                chk($sformatf("v%0d_ram_we", idx), 32'(ram_we),
                    32'(v.kind >= 2));
                if (v.kind >= 2)
                    chk($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wdata);
            end else begin
                chk($sformatf("v%0d_ram_en_off", idx), 32'(ram_en), 32'd0);
            end
            dn = is_data ? d_done : if_done;
            if (dn) got = 1'b1;
            else chk($sformatf("v%0d_stall_busy", idx), 32'(stall), 32'd1);
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d_other_done", idx),
            32'(is_data ? if_done : d_done), 32'd0);
        chk($sformatf("v%0d_rdata", idx),
            is_data ? d_rdata : if_rdata, v.exp_rdata);
        chk($sformatf("v%0d_stall_done", idx), 32'(stall), 32'd0);
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] order;
        int         ng;
        int         cyc;
        bit         got;

        vecs[0] = '{0, 32'h40, 32'h0,        32'h8C010004, 3};
        vecs[1] = '{1, 32'h100, 32'h0,       32'h12345678, 3};
        vecs[2] = '{2, 32'h10, 32'hDEADBEEF, 32'h12345678, 1};
        vecs[3] = '{1, 32'h10, 32'h0,        32'hDEADBEEF, 3};
        vecs[4] = '{3, 32'h20, 32'h0BADF00D, 32'hDEADBEEF, 1};
        vecs[5] = '{1, 32'h20, 32'h0,        32'h0BADF00D, 3};
        vecs[6] = '{0, 32'h80, 32'h0,        32'hCAFEF00D, 3};

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_dones", 32'({if_done, d_done}), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Simultaneous fetch and load: data first, turnaround, then fetch.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h40;
        d_rd    = 1'b1;
        d_addr  = 32'h100;
        @(negedge clk);
        chk("t3_first_grant", ram_addr, 32'h100);
        chk("t3_stall", 32'(stall), 32'd1);
        repeat (2) @(negedge clk);
        chk("t3_d_done", 32'(d_done), 32'd1);
        chk("t3_d_rdata", d_rdata, 32'h12345678);
        chk("t3_if_done_early", 32'(if_done), 32'd0);
        d_rd = 1'b0;
        @(negedge clk);
        chk("t3_turnaround", 32'(ram_en), 32'd0);
        @(negedge clk);
        chk("t3_fetch_en", 32'(ram_en), 32'd1);
        chk("t3_fetch_addr", ram_addr, 32'h40);
        repeat (2) @(negedge clk);
        chk("t3_if_done", 32'(if_done), 32'd1);
        chk("t3_if_rdata", if_rdata, 32'h8C010004);
        if_req = 1'b0;

        // Starvation guard: four data grants, then the fetch gets in.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h80;
        d_rd    = 1'b1;
        d_addr  = 32'h100;
        order   = 6'b0;
        ng      = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if (ram_en) begin
                order = {order[4:0], ram_addr == 32'h100};
                ng++;
                if (ng == 4) chk("t4_run_full", 32'(u_dut.run_q), 32'd4);
                if (ng == 5) chk("t4_run_clear", 32'(u_dut.run_q), 32'd0);
            end
        end
        chk("t4_grants", 32'(ng), 32'd6);
        chk("t4_order", 32'(order), 32'b111101);
        if_req = 1'b0;
        d_rd   = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-stream with every request high.
        if_req  = 1'b1;
        d_rd    = 1'b1;
        d_wr    = 1'b1;
        if_addr = 32'h40;
        d_addr  = 32'h30;
        d_wdata = 32'h55AA55AA;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t1_ram_we", 32'(ram_we), 32'd0);
        chk("t1_ram_addr", ram_addr, 32'h0);
        chk("t1_ram_wdata", ram_wdata, 32'h0);
        chk("t1_if_rdata", if_rdata, 32'h0);
        chk("t1_d_rdata", d_rdata, 32'h0);
        chk("t1_dones", 32'({if_done, d_done}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t1_ram_en_%0d", c), 32'(ram_en), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_en", 32'(ram_en), 32'd1);
        chk("t1_first_we", 32'(ram_we), 32'd1);
        chk("t1_first_addr", ram_addr, 32'h30);
        chk("t1_first_done", 32'(d_done), 32'd1);
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during WAIT on the LATENCY=4 instance.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d_rd   = 1'b1;
        d_addr = 32'h100;
        repeat (2) @(negedge clk);
        chk("t6_pre_done", 32'(d_done4), 32'd0);
        #2 rst_n = 1'b0;
        d_rd = 1'b0;
        @(negedge clk);
        chk("t6_state_idle", 32'(u_dut4.state_q), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t6_no_done_%0d", c), 32'(d_done4), 32'd0);
            chk($sformatf("t6_rdata_%0d", c), d_rdata4, 32'h0);
        end
        d_rd   = 1'b1;
        d_addr = 32'h100;
        cyc    = 0;
        got    = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (d_done4) got = 1'b1;
        end
        chk("t6_latency", 32'(cyc), 32'd5);
        chk("t6_rdata", d_rdata4, 32'h12345678);
        d_rd = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the five-stage pipeline. It shares one unified instruction/data RAM between the IF-stage fetch port and the MEM-stage load/store port. It serialises accesses, waits out a fixed RAM read latency, and returns read data on the requester's port. A `stall` output freezes PC and all pipeline buffers while any request is outstanding.

## Interface
Parameters:
- `LATENCY`, default 2: RAM read latency in clock edges; legal range 1..15. A value of 1 means a combinational-read RAM.
- `MAX_DATA_RUN`, default 4: maximum consecutive data grants while a fetch is pending; legal range 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held by IF until `if_done`.
- `if_addr` in 32: fetch address (PC).
- `if_done` out 1: one-cycle completion pulse for fetch.
- `if_rdata` out 32: fetched instruction, registered.
- `d_rd` in 1: MEM-stage load request.
- `d_wr` in 1: MEM-stage store request.
- `d_addr` in 32: data address (ALU result).
- `d_wdata` in 32: store data.
- `d_done` out 1: one-cycle completion pulse for load/store.
- `d_rdata` out 32: load data, registered.
- `ram_en` out 1: RAM access strobe, registered.
- `ram_we` out 1: RAM write enable, registered.
- `ram_addr` out 32: RAM address, registered.
- `ram_wdata` out 32: RAM write data, registered.
- `ram_rdata` in 32: RAM read data.
- `stall` out 1: combinational; holds PC and pipeline buffers.

## Operation
- FSM states: IDLE, WAIT, DONE. A registered `owner` bit records the granted port: 0 = fetch, 1 = data.
- IDLE, at an edge with any request present:
  - Arbitrate and latch `ram_addr` and `ram_wdata` from the winning port.
  - Drive `ram_en`=1 for exactly one cycle.
  - Read: go to WAIT and load `cnt`=LATENCY.
  - Write: drive `ram_we`=1 and go to DONE.
- WAIT:
  - `ram_en`=0 and `ram_we`=0.
  - `cnt` decrements each edge.
  - At the edge where `cnt`==1: capture `ram_rdata` into the owner's rdata register and go to DONE.
- DONE:
  - The owner's done pulse is high for this single cycle; the other port's done stays 0.
  - The next edge returns to IDLE. This is a turnaround edge: no grant is made, so the stale request still asserted at the same edge is never re-issued.
- Arbitration:
  - Data has priority over fetch, because MEM is the older instruction.
  - Exception: if `run`==MAX_DATA_RUN and `if_req`=1, fetch wins.
- `run` counter:
  - Increments, saturating at MAX_DATA_RUN, on a data grant made while `if_req`=1.
  - Clears on a fetch grant, and on a data grant made with `if_req`=0.
- `d_rd` and `d_wr` both high: treated as a write; the read is ignored.
- Addresses and write data are latched at grant; input changes during WAIT or DONE have no effect.
- A request withdrawn mid-transaction still completes. The done pulse is still issued; the requester ignores it.
- `if_rdata` and `d_rdata` hold their value until that port's next read capture. Writes never modify `d_rdata`.
- `stall` = (`if_req` & ~`if_done`) | ((`d_rd`|`d_wr`) & ~`d_done`).

## Timing
- RAM contract: `ram_rdata` is valid at the LATENCY-th rising edge after the edge that asserted `ram_en`. The RAM performs writes at the edge that ends the `ram_en`/`ram_we` cycle.
- Read, with request sampled at edge E0:
  - `ram_en` is high during E0..E1.
  - Data is captured at E(LATENCY).
  - Done is high during E(LATENCY)..E(LATENCY+1).
- Write, with request sampled at E0: `ram_en`, `ram_we` and `d_done` are all high during E0..E1.
- Earliest next grant after any transaction: the edge after the turnaround edge. Back-to-back read throughput is therefore one access per LATENCY+2 edges.
- Reset, asynchronous, any state (including mid-WAIT):
  - State=IDLE, `owner`=0, `cnt`=0, `run`=0.
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata` = 0.
  - `if_rdata`, `d_rdata` = 0; `if_done`, `d_done` = 0.
  - Any pending capture is discarded and no done pulse is issued.
- After `rst_n` rises, the first edge may grant.

## Test plan
1. Reset asserted mid-stream with all requests high -> every registered output is 0 and no `ram_en` appears. The first grant occurs at the first edge after `rst_n`=1.
2. LATENCY=2, `if_req` with `if_addr`=0x40, RAM returns 0x8C010004 -> `ram_en`=1 and `ram_addr`=0x40 for one cycle. `if_done` is high in cycle E2..E3 with `if_rdata`=0x8C010004. `stall`=1 from request through E2, then 0 during the done cycle.
3. `if_req` and `d_rd` (0x100) asserted in the same cycle -> the data read is granted at E0 and `d_done` pulses in E2..E3. E3 is the turnaround edge; the fetch is granted at E4 and `if_done` pulses in E6..E7.
4. MAX_DATA_RUN=4, data requests held continuously with `if_req`=1 -> grant order is D, D, D, D, F, D…, and `run` returns to 0 after the fetch grant.
5. `d_wr` with `d_addr`=0x10 and `d_wdata`=0xDEADBEEF -> `ram_en`=`ram_we`=1, `ram_wdata`=0xDEADBEEF and `d_done`=1 all in the same cycle. `d_rdata` is unchanged. `d_rd` and `d_wr` both high behave identically to this write.
6. `rst_n` dropped during WAIT (LATENCY=4) -> no done pulse, `d_rdata` stays 0, and the state is IDLE. A re-issued request then completes normally in LATENCY+1 edges.
